// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl
//   Write-back, write-allocate, direct-mapped cache controller with
//   multi-word lines. CPU side: one request at a time with byte strobes.
//   Memory side: valid/ready beat port, one word per beat; refill keeps a
//   single read outstanding. Tag/valid/dirty/data live in internal arrays.
//
// Ports
//   iCLK, iRST_n                    clock (rising edge), async active-low reset
//   cpu_req_valid/ready/rw/addr/wdata/wstrb   CPU request (accepted in IDLE)
//   cpu_resp_valid/rdata            one-cycle response pulse, read or merged word
//   mem_req_valid/ready/we/addr/wdata         memory beat request (registered)
//   mem_resp_valid/rdata            read-beat return data
//
// Optional feature: define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt
// outputs counted on the first lookup of each request.
module cache_line_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 5,
  parameter int WORD_OFF_W = 2
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_rw,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_req_wdata,
  input  logic [DATA_W/8-1:0] cpu_req_wstrb,
  output logic                cpu_resp_valid,
  output logic [DATA_W-1:0]   cpu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int STRB_W     = DATA_W / 8;
  localparam int BYTE_OFF_W = $clog2(STRB_W);
  localparam int TAG_W      = ADDR_W - IDX_W - WORD_OFF_W - BYTE_OFF_W;
  localparam int LINES      = 1 << IDX_W;
  localparam int WORDS      = 1 << WORD_OFF_W;
  localparam int WADDR_W    = ADDR_W - BYTE_OFF_W;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_WRITE_BACK = 3'd2,
    ST_REFILL     = 3'd3,
    ST_RESPOND    = 3'd4
  } state_t;

  state_t state_r, state_nxt_s;

  logic                  req_rw_r;
  logic [WADDR_W-1:0]    req_waddr_r;   // word address; byte offset is dropped
  logic [DATA_W-1:0]     req_wdata_r;
  logic [STRB_W-1:0]     req_wstrb_r;

  logic [TAG_W-1:0]      tag_r  [LINES];
  logic [DATA_W-1:0]     data_r [LINES][WORDS];
  logic [LINES-1:0]      valid_r;
  logic [LINES-1:0]      dirty_r;

  logic [WORD_OFF_W-1:0] beat_r;
  logic                  rd_out_r;      // a refill read is outstanding

  logic [TAG_W-1:0]      req_tag_s;
  logic [IDX_W-1:0]      req_idx_s;
  logic [WORD_OFF_W-1:0] req_word_s;
  logic [WORD_OFF_W-1:0] beat_inc_s;
  logic                  hit_s;
  logic                  victim_dirty_s;
  logic                  accept_s;
  logic                  beat_acc_s;
  logic                  rd_ret_s;
  logic                  last_beat_s;
  logic [DATA_W-1:0]     line_word_s;
  logic [DATA_W-1:0]     merged_s;

  // Byte-lane merge of CPU write data into an existing word.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Word-aligned beat address for a given tag, line index and word slot.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]      t,
                                                  input logic [IDX_W-1:0]      i,
                                                  input logic [WORD_OFF_W-1:0] k);
    return {t, i, k, {BYTE_OFF_W{1'b0}}};
  endfunction

  assign req_tag_s      = req_waddr_r[WADDR_W-1 -: TAG_W];
  assign req_idx_s      = req_waddr_r[WORD_OFF_W +: IDX_W];
  assign req_word_s     = req_waddr_r[WORD_OFF_W-1:0];
  assign beat_inc_s     = beat_r + WORD_OFF_W'(1);
  assign hit_s          = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
  assign victim_dirty_s = valid_r[req_idx_s] && dirty_r[req_idx_s];
  assign accept_s       = cpu_req_valid && cpu_req_ready;
  assign beat_acc_s     = mem_req_valid && mem_req_ready;
  assign rd_ret_s       = (state_r == ST_REFILL) && rd_out_r && mem_resp_valid;
  assign last_beat_s    = (beat_r == WORD_OFF_W'(WORDS - 1));
  assign line_word_s    = data_r[req_idx_s][req_word_s];
  assign merged_s       = merge_bytes(line_word_s, req_wdata_r, req_wstrb_r);

  // State register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_LOOKUP;
        else          state_nxt_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s)               state_nxt_s = ST_RESPOND;
        else if (victim_dirty_s) state_nxt_s = ST_WRITE_BACK;
        else                     state_nxt_s = ST_REFILL;
      end
      ST_WRITE_BACK: begin
        if (beat_acc_s && last_beat_s) state_nxt_s = ST_REFILL;
        else                           state_nxt_s = ST_WRITE_BACK;
      end
      ST_REFILL: begin
        if (rd_ret_s && last_beat_s) state_nxt_s = ST_LOOKUP;
        else                         state_nxt_s = ST_REFILL;
      end
      ST_RESPOND: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Request latch, line status bits, beat sequencing and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= {DATA_W{1'b0}};
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= {ADDR_W{1'b0}};
      mem_req_wdata  <= {DATA_W{1'b0}};
      req_rw_r       <= 1'b0;
      req_waddr_r    <= {WADDR_W{1'b0}};
      req_wdata_r    <= {DATA_W{1'b0}};
      req_wstrb_r    <= {STRB_W{1'b0}};
      valid_r        <= {LINES{1'b0}};
      dirty_r        <= {LINES{1'b0}};
      beat_r         <= {WORD_OFF_W{1'b0}};
      rd_out_r       <= 1'b0;
    end else begin
      cpu_req_ready  <= (state_nxt_s == ST_IDLE);
      cpu_resp_valid <= (state_nxt_s == ST_RESPOND);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            req_rw_r    <= cpu_req_rw;
            req_waddr_r <= cpu_req_addr[ADDR_W-1:BYTE_OFF_W];
            req_wdata_r <= cpu_req_wdata;
            req_wstrb_r <= cpu_req_wstrb;
          end
        end
        ST_LOOKUP: begin
          beat_r <= {WORD_OFF_W{1'b0}};
          if (hit_s) begin
            cpu_resp_rdata <= req_rw_r ? merged_s : line_word_s;
            if (req_rw_r) dirty_r[req_idx_s] <= 1'b1;
          end else if (victim_dirty_s) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= beat_addr(tag_r[req_idx_s], req_idx_s, {WORD_OFF_W{1'b0}});
            mem_req_wdata <= data_r[req_idx_s][0];
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= beat_addr(req_tag_s, req_idx_s, {WORD_OFF_W{1'b0}});
          end
        end
        ST_WRITE_BACK: begin
          if (beat_acc_s) begin
            if (last_beat_s) begin
              // Last write beat accepted: the first refill read goes out next.
              beat_r       <= {WORD_OFF_W{1'b0}};
              mem_req_we   <= 1'b0;
              mem_req_addr <= beat_addr(req_tag_s, req_idx_s, {WORD_OFF_W{1'b0}});
            end else begin
              beat_r        <= beat_inc_s;
              mem_req_addr  <= beat_addr(tag_r[req_idx_s], req_idx_s, beat_inc_s);
              mem_req_wdata <= data_r[req_idx_s][beat_inc_s];
            end
          end
        end
        ST_REFILL: begin
          if (beat_acc_s) begin
            // Read accepted: stay quiet until its data returns.
            mem_req_valid <= 1'b0;
            rd_out_r      <= 1'b1;
          end else if (rd_ret_s) begin
            rd_out_r <= 1'b0;
            if (last_beat_s) begin
              valid_r[req_idx_s] <= 1'b1;
              dirty_r[req_idx_s] <= 1'b0;
              beat_r             <= {WORD_OFF_W{1'b0}};
            end else begin
              beat_r        <= beat_inc_s;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= beat_addr(req_tag_s, req_idx_s, beat_inc_s);
            end
          end
        end
        ST_RESPOND: begin
          beat_r <= {WORD_OFF_W{1'b0}};
        end
        default: begin
          beat_r <= {WORD_OFF_W{1'b0}};
        end
      endcase
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge iCLK) begin
    if (state_r == ST_LOOKUP && hit_s && req_rw_r) begin
      data_r[req_idx_s][req_word_s] <= merged_s;
    end else if (rd_ret_s) begin
      data_r[req_idx_s][beat_r] <= mem_resp_rdata;
      if (last_beat_s) tag_r[req_idx_s] <= req_tag_s;
    end
  end

`ifdef CACHE_STATS_EN
  logic first_lookup_r;   // only the first lookup of a request is counted

  // Saturating hit/miss statistics.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      first_lookup_r <= 1'b0;
      hit_cnt        <= 32'd0;
      miss_cnt       <= 32'd0;
    end else begin
      if (state_r == ST_IDLE && accept_s) first_lookup_r <= 1'b1;
      else if (state_r == ST_LOOKUP)      first_lookup_r <= 1'b0;
      if (state_r == ST_LOOKUP && first_lookup_r) begin
        if (hit_s) begin
          if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
`timescale 1ns/1ps
// Directed bench for cache_line_ctrl with a request-level cache model,
// a beat-level memory responder and a per-cycle compare process.
module tb_cache_line_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b1;
  logic        cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_rw = 1'b0;
  logic [31:0] cpu_req_addr = 32'h0, cpu_req_wdata = 32'h0;
  logic [3:0]  cpu_req_wstrb = 4'h0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = 32'h0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 iCLK = ~iCLK;

  cache_line_ctrl dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- expected beat stream and response ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t       exp_q[$];
  beat_t       cmp_b;
  logic [31:0] exp_rdata = 32'h0;
  bit          resp_expected = 1'b0;

  // ---------------- request-level cache model ----------------
  bit          mv[32];
  bit          md[32];
  logic [31:0] mt[32];
  logic [31:0] mw[32][4];
  logic [31:0] mdl_mem[logic [31:0]];

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_invalidate();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  // Predict beats and the response for one CPU request, updating the model.
  task automatic predict(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, output bit hit, output logic [31:0] e);
    int          idx;
    int          w;
    logic [31:0] tag;
    logic [31:0] a;
    idx = int'((addr >> 4) & 32'h1F);
    w   = int'((addr >> 2) & 32'h3);
    tag = addr >> 9;
    hit = mv[idx] && (mt[idx] == tag);
    if (!hit) begin
      if (mv[idx] && md[idx]) begin
        for (int k = 0; k < 4; k++) begin
          a = (mt[idx] << 9) | (idx << 4) | (k << 2);
          exp_q.push_back('{we: 1'b1, addr: a, data: mw[idx][k]});
          mdl_mem[a] = mw[idx][k];
        end
      end
      for (int k = 0; k < 4; k++) begin
        a = (tag << 9) | (idx << 4) | (k << 2);
        exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
        mw[idx][k] = mdl_read(a);
      end
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tag;
    end
    e = mw[idx][w];
    if (rw) begin
      for (int b = 0; b < 4; b++) if (ws[b]) e[8*b +: 8] = wd[8*b +: 8];
      mw[idx][w] = e;
      md[idx]    = 1'b1;
    end
  endtask

  task automatic drive_req(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws);
    @(negedge iCLK);
    check("ready_idle", cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    cpu_req_wstrb = ws;
    @(posedge iCLK);
    #1;
    // Inputs are free to change once the request is taken.
    cpu_req_valid = 1'b0;
    cpu_req_rw    = 1'($urandom_range(0, 1));
    cpu_req_addr  = $urandom;
    cpu_req_wdata = $urandom;
    cpu_req_wstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic do_req(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input bit exp_hit, input logic [31:0] lit);
    bit          hit;
    bit          got;
    int          n;
    logic [31:0] e;
    predict(rw, addr, wd, ws, hit, e);
    check("model_hit", hit, exp_hit);
    check("model_data", e, lit);
    exp_rdata     = e;
    resp_expected = 1'b1;
    drive_req(rw, addr, wd, ws);
    n   = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      @(negedge iCLK);
      n++;
      if (cpu_resp_valid) got = 1'b1;
      else check("ready_busy", cpu_req_ready, 1'b0);
    end
    if (!got) begin
      n_total++;
      $display("FAIL resp_timeout: got no response, expected one within 400 cycles (addr 0x%0h)", addr);
    end else begin
      if (exp_hit) check("hit_latency", n, 2);
      @(negedge iCLK);
      check("resp_pulse", cpu_resp_valid, 1'b0);
      check("ready_after", cpu_req_ready, 1'b1);
    end
    check("beats_left", exp_q.size(), 0);
    resp_expected = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] ram[logic [31:0]];
  bit          acc = 1'b0;
  logic        acc_we;
  logic [31:0] acc_a, acc_d;
  int          stall_left = 0;

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(negedge iCLK) begin
    acc    = iRST_n && mem_req_valid && mem_req_ready;
    acc_we = mem_req_we;
    acc_a  = mem_req_addr;
    acc_d  = mem_req_wdata;
  end

  always @(posedge iCLK) begin
    #1;
    mem_resp_valid = 1'b0;
    if (acc) begin
      if (acc_we) ram[acc_a] = acc_d;
      else begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = ram_read(acc_a);
      end
    end
    acc = 1'b0;
    if (stall_left > 0) begin
      if (mem_req_valid) stall_left--;
      mem_req_ready = 1'b0;
    end else begin
      mem_req_ready = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          p_stall = 1'b0;
  bit          rd_chk = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_data;
  int          stall_seen = 0;

  always @(negedge iCLK) begin
    if (!iRST_n) begin
      p_stall = 1'b0;
      rd_chk  = 1'b0;
    end else begin
      if (p_stall)
        check("hold_stable", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata},
              {1'b1, p_we, p_addr, p_data});
      if (rd_chk) check("valid_low_wait", mem_req_valid, 1'b0);
      rd_chk = 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got beat we=%0b addr=0x%0h, expected none", mem_req_we, mem_req_addr);
        end else begin
          cmp_b = exp_q.pop_front();
          check("beat_we", mem_req_we, cmp_b.we);
          check("beat_addr", mem_req_addr, cmp_b.addr);
          if (cmp_b.we) check("beat_wdata", mem_req_wdata, cmp_b.data);
        end
        rd_chk = !mem_req_we;
      end
      if (cpu_resp_valid) begin
        if (!resp_expected) begin
          n_total++;
          $display("FAIL unexpected_resp: got rdata 0x%0h, expected no response", cpu_resp_rdata);
        end else begin
          check("resp_rdata", cpu_resp_rdata, exp_rdata);
        end
      end
      p_stall = mem_req_valid && !mem_req_ready;
      if (p_stall) stall_seen++;
      p_we   = mem_req_we;
      p_addr = mem_req_addr;
      p_data = mem_req_wdata;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit          hit6;
    bit          found;
    int          n;
    logic [31:0] e6;
    model_invalidate();
    #2 iRST_n = 1'b0;
    repeat (2) @(negedge iCLK);
    check("reset_outputs",
          {cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata},
          {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0});
`ifdef CACHE_STATS_EN
    check("reset_stats", {hit_cnt, miss_cnt}, 64'h0);
`endif
    iRST_n = 1'b1;

    // 1: cold miss, then a hit in the same line
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 32'hA5A5_0040);
    do_req(1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b1, 32'hA5A5_0044);
    // 2: full-word write hit, read back
    do_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);
    // 3: conflict miss on a dirty line
    check("model_victim_w1", mw[4][1], 32'hA5A5_0044);
    do_req(1'b0, 32'h0000_0240, 32'h0, 4'h0, 1'b0, 32'hA5A5_0240);
    check("ram_wb_w0", ram_read(32'h0000_0040), 32'hDEAD_BEEF);
    // 4: partial-byte writes
    do_req(1'b1, 32'h0000_0244, 32'h0000_00AA, 4'h1, 1'b1, 32'hA5A5_02AA);
    do_req(1'b0, 32'h0000_0244, 32'h0, 4'h0, 1'b1, 32'hA5A5_02AA);
    do_req(1'b1, 32'h0000_0248, 32'h1122_3344, 4'hA, 1'b1, 32'h11A5_3348);
    // 5: memory stalls the first refill beat for 10 cycles
    stall_seen = 0;
    stall_left = 10;
    do_req(1'b0, 32'h0000_0080, 32'h0, 4'h0, 1'b0, 32'hA5A5_0080);
    check("stall_cycles", stall_seen, 10);

    // 6: reset in the middle of refill beat 2
    predict(1'b0, 32'h0000_0040, 32'h0, 4'h0, hit6, e6);
    check("model_hit6", hit6, 1'b0);
    drive_req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    n     = 0;
    found = 1'b0;
    while (n < 300 && !found) begin
      @(posedge iCLK);
      #2;
      n++;
      if (mem_req_valid && !mem_req_we && mem_req_addr == 32'h0000_0048) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL beat2_timeout: got no refill beat at 0x48, expected one within 300 cycles");
    end
    check("beats_before_reset", exp_q.size(), 2);
    iRST_n = 1'b0;
    #1;
    check("reset_drops_valid", mem_req_valid, 1'b0);
    exp_q.delete();
    model_invalidate();
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    @(negedge iCLK);
    check("ready_after_reset", cpu_req_ready, 1'b1);
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
`ifdef CACHE_STATS_EN
    check("stats_after_reset", {hit_cnt, miss_cnt}, {32'd0, 32'd1});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
